// File: rtl/acc_unit_pkg.sv
// Shared tile types for the accumulator: lane vector, FSM states, and a single-precision add helper.
// Lane geometry comes from the QW (lane width) and XW (lane count) macros.
`ifndef QW
`define QW 32
`endif
`ifndef XW
`define XW 4
`endif

package acc_unit_pkg;

  typedef logic [`XW-1:0][`QW-1:0] lane_vec_t;

  typedef enum logic {ACC, OUT} acc_state_e;

  localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;

  // IEEE-754 binary32 add, round-to-nearest-even, subnormals kept, NaN results canonical.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] ax, ay, ay_sh, m, mask;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] rm;
    logic        rnd, a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    if (a_nan || b_nan) return FP_QNAN;
    if (a_inf) return (b_inf && (a[31] != b[31])) ? FP_QNAN : a;
    if (b_inf) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    d  = ex - ey;
    ax = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    ay = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    // three guard bits; everything shifted past them folds into the sticky bit
    if (d >= 8'd27) begin
      ay_sh = {26'd0, (ay != 27'd0)};
    end else begin
      mask  = (27'd1 << d) - 27'd1;
      ay_sh = (ay >> d) | {26'd0, |(ay & mask)};
    end
    e = {2'b00, ex};
    if (x[31] == y[31]) begin
      sum = {1'b0, ax} + {1'b0, ay_sh};
      if (sum[27]) begin
        m = sum[27:1] | {26'd0, sum[0]};
        e = e + 10'd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = ax - ay_sh;
      if (m == 27'd0) return 32'h0000_0000;
      for (int i = 0; i < 26; i++) begin
        if (!m[26] && (e > 10'd1)) begin
          m = m << 1;
          e = e - 10'd1;
        end
      end
    end
    rnd = m[2] && (m[1] || m[0] || m[3]);
    rm  = {1'b0, m[26:3]} + {24'd0, rnd};
    if (rm[24]) begin
      rm = rm >> 1;
      e  = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    return {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
  endfunction

endpackage

// File: rtl/acc_unit_fp_vec_add.sv
// Combinational lane-wise binary32 adder over XW lanes.
// Latency: zero cycles; no flow control.
module fp_vec_add
  import acc_unit_pkg::*;
(
  input  logic [`XW-1:0][`QW-1:0] a,
  input  logic [`XW-1:0][`QW-1:0] b,
  output logic [`XW-1:0][`QW-1:0] y
);

  for (genvar i = 0; i < `XW; i++) begin : g_lane
    assign y[i] = fp_add(a[i], b[i]);
  end

endmodule

// File: rtl/acc_unit.sv
// Sums NACC partial-sum vectors lane-wise (binary32) into one output vector; ACC_BIAS_EN adds bias_i to each group.
// Latency: result valid one cycle after the last beat of a group; a take plus a new beat in the same cycle leaves no bubble.
// Backpressure: while a result is held, ready_o follows ready_i; no path from valid_i to ready_o.
module acc_unit
  import acc_unit_pkg::*;
#(
  parameter int NACC = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [`XW-1:0][`QW-1:0] data_i,
`ifdef ACC_BIAS_EN
  input  logic [`XW-1:0][`QW-1:0] bias_i,
`endif
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [`XW-1:0][`QW-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int               CNT_W    = $clog2(NACC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NACC - 1);

  acc_state_e       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  lane_vec_t        acc, add_a, add_y, sum_v;
  logic             accept, last, acc_we, out_we;

  assign valid_o = (state == OUT);
  assign ready_o = (state == ACC) || ready_i;
  assign accept  = valid_i && ready_o;
  assign last    = (cnt == CNT_LAST);

`ifdef ACC_BIAS_EN
  assign add_a = (cnt == '0) ? bias_i : acc;
  assign sum_v = add_y;
`else
  // first beat of a group is loaded verbatim so a -0.0 lane survives
  assign add_a = acc;
  assign sum_v = (cnt == '0) ? data_i : add_y;
`endif

  fp_vec_add u_add (
    .a (add_a),
    .b (data_i),
    .y (add_y)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    acc_we    = 1'b0;
    out_we    = 1'b0;
    case (state)
      ACC:     nxt_state = ACC;
      OUT:     if (ready_i) nxt_state = ACC;
      default: nxt_state = ACC;
    endcase
    if (accept) begin
      acc_we = 1'b1;
      if (last) begin
        out_we    = 1'b1;
        nxt_cnt   = '0;
        nxt_state = OUT;
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ACC;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      data_o <= '0;
    end else begin
      if (acc_we) acc <= sum_v;
      if (out_we) data_o <= sum_v;
    end
  end

endmodule
